// File: rtl/fetch_inst_buffer.sv
// Instruction queue between icache and decode: compacts 2-slot fetch
// packets into single-instruction entries and issues up to 2 per cycle.
module fetch_inst_buffer #(
   parameter int DEPTH  = 16,
   parameter int PRED_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [31:0]             in_pc_i,
   input  logic [1:0]              in_mask_i,
   input  logic [63:0]             in_insts_i,
   input  logic [2*PRED_W-1:0]     in_pred_i,
   output logic                    out_valid_o,
   output logic [1:0]              out_mask_o,
   input  logic                    out_ready_i,
   output logic [63:0]             out_insts_o,
   output logic [63:0]             out_pc_o,
   output logic [2*PRED_W-1:0]     out_pred_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - 2);

   logic [31:0]       r_inst [DEPTH];
   logic [31:0]       r_pc   [DEPTH];
   logic [PRED_W-1:0] r_pred [DEPTH];

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic              w_ready;
   logic [1:0]        w_omask;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_npush;
   logic [1:0]        w_npop;
   logic [AW-1:0]     w_head1;
   logic [AW-1:0]     w_tail1;
   logic              w_we_a;
   logic              w_we_b;
   logic [31:0]       w_pc1;
   logic [31:0]       w_a_inst;
   logic [31:0]       w_a_pc;
   logic [PRED_W-1:0] w_a_pred;

   // Ready is conservative: room for a full packet, ignoring any pop.
   assign w_ready = (r_count <= READY_LIM);
   assign w_omask = {r_count >= CW'(2), r_count != '0};

   assign w_push  = in_valid_i & w_ready & ~flush_i;
   assign w_pop   = (|w_omask) & out_ready_i & ~flush_i;

   assign w_npush = w_push
                  ? ({1'b0, in_mask_i[0]} + {1'b0, in_mask_i[1]})
                  : 2'd0;
   assign w_npop  = w_pop
                  ? ({1'b0, w_omask[0]} + {1'b0, w_omask[1]})
                  : 2'd0;

   assign w_head1 = r_head + AW'(1);
   assign w_tail1 = r_tail + AW'(1);
   assign w_pc1   = in_pc_i + 32'd4;

   // Port A takes slot 0 if valid, else slot 1 (compaction of mask 10).
   assign w_we_a   = w_push & (|in_mask_i);
   assign w_we_b   = w_push & (&in_mask_i);
   assign w_a_inst = in_mask_i[0] ? in_insts_i[31:0] : in_insts_i[63:32];
   assign w_a_pc   = in_mask_i[0] ? in_pc_i : w_pc1;
   assign w_a_pred = in_mask_i[0] ? in_pred_i[PRED_W-1:0]
                                  : in_pred_i[2*PRED_W-1:PRED_W];

   always_ff @(posedge clk) begin
      if (w_we_a) begin
         r_inst[r_tail] <= w_a_inst;
         r_pc[r_tail]   <= w_a_pc;
         r_pred[r_tail] <= w_a_pred;
      end
      if (w_we_b) begin
         r_inst[w_tail1] <= in_insts_i[63:32];
         r_pc[w_tail1]   <= w_pc1;
         r_pred[w_tail1] <= in_pred_i[2*PRED_W-1:PRED_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_npop);
         r_tail  <= r_tail + AW'(w_npush);
         r_count <= r_count + CW'(w_npush) - CW'(w_npop);
      end
   end

   always_comb begin
      out_insts_o = '0;
      out_pc_o    = '0;
      out_pred_o  = '0;
      if (w_omask[0]) begin
         out_insts_o[31:0]       = r_inst[r_head];
         out_pc_o[31:0]          = r_pc[r_head];
         out_pred_o[PRED_W-1:0]  = r_pred[r_head];
      end
      if (w_omask[1]) begin
         out_insts_o[63:32]             = r_inst[w_head1];
         out_pc_o[63:32]                = r_pc[w_head1];
         out_pred_o[2*PRED_W-1:PRED_W]  = r_pred[w_head1];
      end
   end

   assign in_ready_o  = w_ready;
   assign out_valid_o = |w_omask;
   assign out_mask_o  = w_omask;
   assign count_o     = r_count;

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Bench for fetch_inst_buffer: directed steps plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_fetch_inst_buffer;

   localparam int DEPTH  = 16;
   localparam int PRED_W = 32;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                flush_i = 1'b0;
   logic                in_valid_i = 1'b0;
   logic                in_ready_o;
   logic [31:0]         in_pc_i = '0;
   logic [1:0]          in_mask_i = '0;
   logic [63:0]         in_insts_i = '0;
   logic [2*PRED_W-1:0] in_pred_i = '0;
   logic                out_valid_o;
   logic [1:0]          out_mask_o;
   logic                out_ready_i = 1'b0;
   logic [63:0]         out_insts_o;
   logic [63:0]         out_pc_o;
   logic [2*PRED_W-1:0] out_pred_o;
   logic [4:0]          count_o;

   fetch_inst_buffer #(.DEPTH(DEPTH), .PRED_W(PRED_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_pc_i(in_pc_i), .in_mask_i(in_mask_i),
      .in_insts_i(in_insts_i), .in_pred_i(in_pred_i),
      .out_valid_o(out_valid_o), .out_mask_o(out_mask_o),
      .out_ready_i(out_ready_i), .out_insts_o(out_insts_o),
      .out_pc_o(out_pc_o), .out_pred_o(out_pred_o),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   ent_t q[$];
   int n_tests = 0;
   int n_fail = 0;
   logic [31:0] pc_ctr = 32'h8000_0000;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected outputs follow directly from queue contents.
   task automatic check_model();
      int sz;
      logic [63:0] e_ins, e_pc, e_pr;
      logic [1:0] e_m;
      sz = q.size();
      e_ins = '0; e_pc = '0; e_pr = '0;
      e_m = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
      if (sz >= 1) begin
         e_ins[31:0] = q[0].inst;
         e_pc[31:0]  = q[0].pc;
         e_pr[31:0]  = q[0].pred;
      end
      if (sz >= 2) begin
         e_ins[63:32] = q[1].inst;
         e_pc[63:32]  = q[1].pc;
         e_pr[63:32]  = q[1].pred;
      end
      check("m_count", 64'(count_o), 64'(sz));
      check("m_ready", 64'(in_ready_o), 64'(DEPTH - sz >= 2));
      check("m_valid", 64'(out_valid_o), 64'(sz > 0));
      check("m_mask", 64'(out_mask_o), 64'(e_m));
      check("m_insts", out_insts_o, e_ins);
      check("m_pc", out_pc_o, e_pc);
      check("m_pred", out_pred_o, e_pr);
   endtask

   task automatic drive(bit v, logic [1:0] m, logic [31:0] pc,
                        logic [63:0] ins, bit rdy, bit fl);
      in_valid_i  = v;
      in_mask_i   = m;
      in_pc_i     = pc;
      in_insts_i  = ins;
      in_pred_i   = {$urandom, $urandom};
      out_ready_i = rdy;
      flush_i     = fl;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [31:0] next_pc();
      pc_ctr = pc_ctr + 32'd8;
      return pc_ctr;
   endfunction

   // One clock: decide handshakes from pre-edge model, advance, compare.
   task automatic tick();
      bit do_push;
      int npop;
      ent_t e;
      do_push = rst_n && in_valid_i && !flush_i && (DEPTH - q.size() >= 2);
      npop = 0;
      if (rst_n && !flush_i && out_ready_i)
         npop = (q.size() >= 2) ? 2 : q.size();
      @(posedge clk);
      #1;
      if (!rst_n || flush_i) begin
         q.delete();
      end else begin
         repeat (npop) void'(q.pop_front());
         if (do_push && in_mask_i[0]) begin
            e.inst = in_insts_i[31:0];
            e.pc   = in_pc_i;
            e.pred = in_pred_i[31:0];
            q.push_back(e);
         end
         if (do_push && in_mask_i[1]) begin
            e.inst = in_insts_i[63:32];
            e.pc   = in_pc_i + 32'd4;
            e.pred = in_pred_i[63:32];
            q.push_back(e);
         end
      end
      check_model();
   endtask

   initial begin
      // Reset
      drive(0, 2'b00, 32'h0, 64'h0, 0, 0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_ready", 64'(in_ready_o), 64'd1);
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_insts", out_insts_o, 64'd0);
      check("rst_pc", out_pc_o, 64'd0);
      check("rst_pred", out_pred_o, 64'd0);

      // Basic 2-slot push
      drive(1, 2'b11, 32'h1c00_0000, 64'hBBBB0002_AAAA0001, 1, 0);
      tick();
      check("basic_mask", 64'(out_mask_o), 64'd3);
      check("basic_pc", out_pc_o, 64'h1c000004_1c000000);
      check("basic_insts", out_insts_o, 64'hBBBB0002_AAAA0001);
      drive(0, 2'b00, 32'h0, 64'h0, 1, 0);
      tick();
      check("basic_drain", 64'(count_o), 64'd0);

      // Mask 10 compaction
      drive(1, 2'b10, 32'h1c00_0008, 64'hCCCC0003_DEADBEEF, 0, 0);
      tick();
      check("m10_mask", 64'(out_mask_o), 64'd1);
      check("m10_insts", out_insts_o, 64'h00000000_CCCC0003);
      check("m10_pc", out_pc_o, 64'h00000000_1c00000c);
      drive(0, 2'b00, 32'h0, 64'h0, 1, 0);
      tick();
      check("m10_drain", 64'(count_o), 64'd0);

      // Full boundary
      for (int i = 0; i < 7; i++) begin
         drive(1, 2'b11, next_pc(), rnd64(), 0, 0);
         tick();
      end
      check("full14_count", 64'(count_o), 64'd14);
      check("full14_ready", 64'(in_ready_o), 64'd1);
      drive(1, 2'b11, next_pc(), rnd64(), 0, 0);
      tick();
      check("full16_count", 64'(count_o), 64'd16);
      check("full16_ready", 64'(in_ready_o), 64'd0);
      drive(1, 2'b11, next_pc(), rnd64(), 0, 0);
      tick();
      check("full_hold", 64'(count_o), 64'd16);
      drive(0, 2'b00, 32'h0, 64'h0, 1, 0);
      tick();
      check("full_pop_count", 64'(count_o), 64'd14);
      check("full_pop_ready", 64'(in_ready_o), 64'd1);
      for (int i = 0; i < 7; i++) tick();
      check("full_drain", 64'(count_o), 64'd0);

      // Flush with simultaneous push and pop
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'b11, next_pc(), rnd64(), 0, 0);
         tick();
      end
      check("fl_pre", 64'(count_o), 64'd6);
      drive(1, 2'b11, 32'h1234_5670, rnd64(), 1, 1);
      tick();
      check("fl_count", 64'(count_o), 64'd0);
      check("fl_valid", 64'(out_valid_o), 64'd0);
      check("fl_ready", 64'(in_ready_o), 64'd1);
      drive(0, 2'b00, 32'h0, 64'h0, 1, 0);
      tick();
      check("fl_gone", 64'(out_valid_o), 64'd0);

      // Wrap with continuous pops, cycling masks 01/11/10
      for (int i = 0; i < 60; i++) begin
         logic [1:0] m;
         m = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b11 : 2'b10;
         drive(1, m, next_pc(), rnd64(), 1, 0);
         tick();
      end

      // Randomized traffic, including a mid-run reset
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(3, 0) != 0, 2'($urandom_range(3, 0)),
               next_pc(), rnd64(), $urandom_range(9, 0) < 6,
               $urandom_range(49, 0) == 0);
         rst_n = (i != 200);
         tick();
      end
      rst_n = 1'b1;

      drive(0, 2'b00, 32'h0, 64'h0, 1, 0);
      for (int i = 0; i < 10; i++) tick();
      check("end_empty", 64'(count_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
